// File: rtl/array_resp.sv
// Array-end responder for the memory-array bus: row session FSM, reduced-depth
// storage, fixed-latency read pipeline, tRCD/tRP checks and refresh counting.
module array_resp #(
  parameter int ARRAY_COL_ADDR_WIDTH = 6,
  parameter int ARRAY_ROW_ADDR_WIDTH = 16,
  parameter int ARRAY_DATA_WIDTH     = 64,
  parameter int MODEL_ROW_BITS       = 4,
  parameter int TRCD                 = 3,
  parameter int TRP                  = 2,
  parameter int RD_LAT               = 2
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            array_cs_n,
  input  logic [ARRAY_ROW_ADDR_WIDTH-1:0] array_raddr,
  input  logic                            array_caddr_vld_wr,
  input  logic [ARRAY_COL_ADDR_WIDTH-1:0] array_caddr_wr,
  input  logic                            array_wdata_vld,
  input  logic [ARRAY_DATA_WIDTH-1:0]     array_wdata,
  input  logic                            array_caddr_vld_rd,
  input  logic [ARRAY_COL_ADDR_WIDTH-1:0] array_caddr_rd,
  output logic [ARRAY_DATA_WIDTH-1:0]     array_rdata,
  output logic                            array_rdata_vld,
  output logic                            array_err_trcd,
  output logic                            array_err_trp,
  output logic                            array_err_conflict,
  output logic [15:0]                     array_rf_cnt
);
  // state  | meaning
  // IDLE   | no session, chip select high
  // ACT    | session open, waiting out tRCD; column commands ignored
  // ACTIVE | column writes/reads accepted
  // PRE    | session closed, waiting out tRP
  localparam int AW    = MODEL_ROW_BITS + ARRAY_COL_ADDR_WIDTH;
  localparam int DEPTH = 1 << AW;
  localparam int TMAX  = (TRCD > TRP) ? TRCD : TRP;
  localparam int CW    = $clog2(TMAX + 1);

  typedef enum logic [1:0] {IDLE, ACT, ACTIVE, PRE} state_e;

  state_e                    state_q, state_d;
  logic [CW-1:0]             cnt_q, cnt_d;
  logic [MODEL_ROW_BITS-1:0] row_q, row_d;
  logic                      seen_q, seen_d;
  logic [15:0]               rf_cnt_q, rf_cnt_d;
  logic                      err_trcd_q, err_trcd_d;
  logic                      err_trp_q, err_trp_d;
  logic                      err_conflict_q, err_conflict_d;
  logic                      start, end_s, col_en, wr_en, rd_en, cmd;

  logic [ARRAY_DATA_WIDTH-1:0] mem [DEPTH];
  logic [ARRAY_DATA_WIDTH-1:0] pipe_data_q [RD_LAT];
  logic [RD_LAT-1:0]           pipe_vld_q;
  logic [ARRAY_DATA_WIDTH-1:0] rdata_q;
  logic                        rdata_vld_q;

  // Upper row bits alias onto the modelled rows by design.
  logic unused_raddr;
  assign unused_raddr = ^array_raddr[ARRAY_ROW_ADDR_WIDTH-1:MODEL_ROW_BITS];

  assign cmd = array_caddr_vld_wr | array_caddr_vld_rd;

  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    row_d          = row_q;
    seen_d         = seen_q;
    rf_cnt_d       = rf_cnt_q;
    err_trcd_d     = err_trcd_q;
    err_trp_d      = err_trp_q;
    err_conflict_d = err_conflict_q;
    start          = 1'b0;
    end_s          = 1'b0;
    col_en         = 1'b0;
    wr_en          = 1'b0;
    rd_en          = 1'b0;
    unique case (state_q)
      IDLE: if (!array_cs_n) start = 1'b1;
      ACT: begin
        if (array_cs_n) begin
          end_s = 1'b1;
        end else if (cnt_q == '0) begin
          state_d = ACTIVE;
          col_en  = 1'b1;
        end else begin
          cnt_d = cnt_q - CW'(1);
          if (cmd) begin
            err_trcd_d = 1'b1;
            seen_d     = 1'b1;
          end
        end
      end
      ACTIVE: begin
        if (array_cs_n) end_s = 1'b1;
        else            col_en = 1'b1;
      end
      PRE: begin
        if (!array_cs_n) begin
          start = 1'b1;
          if (cnt_q != '0) err_trp_d = 1'b1;
        end else if (cnt_q == '0) begin
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    if (start) begin
      state_d = ACT;
      row_d   = array_raddr[MODEL_ROW_BITS-1:0];
      cnt_d   = CW'(TRCD - 1);
      seen_d  = 1'b0;
    end
    // A session with no column command at all is a refresh.
    if (end_s) begin
      state_d = PRE;
      cnt_d   = CW'(TRP - 1);
      if (!seen_q) rf_cnt_d = rf_cnt_q + 16'd1;
    end
    if (col_en) begin
      if (cmd) seen_d = 1'b1;
      wr_en = array_caddr_vld_wr & array_wdata_vld;
      rd_en = array_caddr_vld_rd;
      if (wr_en && rd_en) err_conflict_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= IDLE;
      cnt_q          <= '0;
      row_q          <= '0;
      seen_q         <= 1'b0;
      rf_cnt_q       <= '0;
      err_trcd_q     <= 1'b0;
      err_trp_q      <= 1'b0;
      err_conflict_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      row_q          <= row_d;
      seen_q         <= seen_d;
      rf_cnt_q       <= rf_cnt_d;
      err_trcd_q     <= err_trcd_d;
      err_trp_q      <= err_trp_d;
      err_conflict_q <= err_conflict_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[{row_q, array_caddr_wr}] <= array_wdata;
  end

  // Nonblocking storage read: a same-cycle write is not visible to the read.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pipe_vld_q  <= '0;
      rdata_q     <= '0;
      rdata_vld_q <= 1'b0;
      for (int i = 0; i < RD_LAT; i++) pipe_data_q[i] <= '0;
    end else begin
      pipe_vld_q[0] <= rd_en;
      if (rd_en) pipe_data_q[0] <= mem[{row_q, array_caddr_rd}];
      for (int i = 1; i < RD_LAT; i++) begin
        pipe_vld_q[i]  <= pipe_vld_q[i-1];
        pipe_data_q[i] <= pipe_data_q[i-1];
      end
      rdata_vld_q <= pipe_vld_q[RD_LAT-1];
      if (pipe_vld_q[RD_LAT-1]) rdata_q <= pipe_data_q[RD_LAT-1];
    end
  end

  assign array_rdata        = rdata_q;
  assign array_rdata_vld    = rdata_vld_q;
  assign array_err_trcd     = err_trcd_q;
  assign array_err_trp      = err_trp_q;
  assign array_err_conflict = err_conflict_q;
  assign array_rf_cnt       = rf_cnt_q;

endmodule

// File: tb/tb_array_resp.sv
// Scoreboarded bench for array_resp: directed sessions plus random sessions,
// checked against a cycle-level protocol model of the array.
`timescale 1ns/1ps
module tb_array_resp;
  localparam int TRCD   = 3;
  localparam int TRP    = 2;
  localparam int RD_LAT = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        array_cs_n = 1'b1;
  logic [15:0] array_raddr = '0;
  logic        array_caddr_vld_wr = 1'b0;
  logic [5:0]  array_caddr_wr = '0;
  logic        array_wdata_vld = 1'b0;
  logic [63:0] array_wdata = '0;
  logic        array_caddr_vld_rd = 1'b0;
  logic [5:0]  array_caddr_rd = '0;
  logic [63:0] array_rdata;
  logic        array_rdata_vld;
  logic        array_err_trcd, array_err_trp, array_err_conflict;
  logic [15:0] array_rf_cnt;

  array_resp #(.TRCD(TRCD), .TRP(TRP), .RD_LAT(RD_LAT)) dut (
    .clk(clk), .rst_n(rst_n), .array_cs_n(array_cs_n), .array_raddr(array_raddr),
    .array_caddr_vld_wr(array_caddr_vld_wr), .array_caddr_wr(array_caddr_wr),
    .array_wdata_vld(array_wdata_vld), .array_wdata(array_wdata),
    .array_caddr_vld_rd(array_caddr_vld_rd), .array_caddr_rd(array_caddr_rd),
    .array_rdata(array_rdata), .array_rdata_vld(array_rdata_vld),
    .array_err_trcd(array_err_trcd), .array_err_trp(array_err_trp),
    .array_err_conflict(array_err_conflict), .array_rf_cnt(array_rf_cnt));

  always #5 clk = ~clk;

  int cyc_n = 0;
  always @(posedge clk) cyc_n <= cyc_n + 1;

  int total = 0;
  int bad   = 0;

  typedef struct {logic [63:0] d; bit known; int cyc;} exp_t;
  exp_t sbq[$];

  // Reference model state
  logic [63:0] mdl_mem [int];
  bit          m_in_sess;
  int          m_k, m_gap;
  bit          m_seen;
  logic [3:0]  m_row;
  bit          e_trcd, e_trp, e_conf;
  logic [15:0] e_rf;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%h want=%h", nm, act, exp);
    end
  endtask

  task automatic model_reset();
    m_in_sess = 0; m_k = 0; m_gap = 1000; m_seen = 0; m_row = '0;
    e_trcd = 0; e_trp = 0; e_conf = 0; e_rf = '0;
    sbq.delete();
  endtask

  // Drives one cycle, then applies the protocol rules for that sampling edge.
  task automatic step(input bit cs_n, input logic [15:0] ra = '0,
                      input bit rdv = 0, input int rcol = 0,
                      input bit wrv = 0, input bit wdv = 0, input int wcol = 0,
                      input logic [63:0] wd = '0);
    int   ridx, widx;
    exp_t e;
    array_cs_n = cs_n; array_raddr = ra;
    array_caddr_vld_rd = rdv; array_caddr_rd = 6'(rcol);
    array_caddr_vld_wr = wrv; array_wdata_vld = wdv;
    array_caddr_wr = 6'(wcol); array_wdata = wd;
    @(posedge clk);
    #1;
    if (!m_in_sess) begin
      m_gap++;
      if (!cs_n) begin
        if (m_gap < TRP) e_trp = 1;
        m_in_sess = 1; m_k = 0; m_seen = 0; m_row = ra[3:0];
      end
    end else begin
      m_k++;
      if (cs_n) begin
        m_in_sess = 0; m_gap = 0;
        if (!m_seen) e_rf = e_rf + 16'd1;
      end else begin
        if (rdv || wrv) m_seen = 1;
        if (m_k < TRCD) begin
          if (rdv || wrv) e_trcd = 1;
        end else begin
          ridx = int'({m_row, 6'(rcol)});
          widx = int'({m_row, 6'(wcol)});
          if (rdv) begin
            e.known = mdl_mem.exists(ridx);
            e.d     = e.known ? mdl_mem[ridx] : '0;
            e.cyc   = cyc_n + RD_LAT;
            sbq.push_back(e);
          end
          if (wrv && wdv) mdl_mem[widx] = wd;
          if (rdv && wrv && wdv) e_conf = 1;
        end
      end
    end
  endtask

  task automatic chk_flags(input string tag);
    chk({tag, ".err_trcd"}, 64'(array_err_trcd), 64'(e_trcd));
    chk({tag, ".err_trp"}, 64'(array_err_trp), 64'(e_trp));
    chk({tag, ".err_conflict"}, 64'(array_err_conflict), 64'(e_conf));
    chk({tag, ".rf_cnt"}, 64'(array_rf_cnt), 64'(e_rf));
  endtask

  task automatic drain(input string tag);
    for (int i = 0; i < 20 && sbq.size() != 0; i++) @(posedge clk);
    @(negedge clk);
    chk({tag, ".pending_reads"}, 64'(sbq.size()), 64'd0);
  endtask

  // Monitor: every response pulse must match the oldest outstanding read.
  exp_t mon_e;
  always @(negedge clk) begin
    if (rst_n && array_rdata_vld) begin
      if (sbq.size() == 0) begin
        total++; bad++;
        $display("FAIL unexpected_rdata_vld got=1 want=0 data=%h", array_rdata);
      end else begin
        mon_e = sbq.pop_front();
        chk("rd_latency_cycle", 64'(mon_e.cyc), 64'(cyc_n));
        chk("rd_latency_cycle_exp", 64'(cyc_n), 64'(mon_e.cyc));
        if (mon_e.known) chk("rd_data", array_rdata, mon_e.d);
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog got=timeout want=finish");
    $display("test done: total=%0d bad=%0d", total, bad + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    int len, g;
    model_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst.rdata", array_rdata, 64'd0);
    chk("rst.rdata_vld", 64'(array_rdata_vld), 64'd0);
    chk_flags("rst");
    @(posedge clk); #1; rst_n = 1'b1;
    step(1);

    // Basic write then read in a new session, row 0x0003 col 5.
    step(0, 16'h0003);
    step(0); step(0);
    step(0, 16'h0003, 0, 0, 1, 1, 5, 64'hDEAD_BEEF_0123_4567);
    step(1); step(1); step(1);
    step(0, 16'h0003); step(0); step(0);
    step(0, 16'h0003, 1, 5);
    step(1); step(1); step(1);
    drain("basic");
    chk_flags("basic");

    // Column write at session cycle 1 is ignored and flagged.
    step(0, 16'h0003);
    step(0, 16'h0003, 0, 0, 1, 1, 5, 64'h1111_2222_3333_4444);
    step(0);
    step(0, 16'h0003, 1, 5);
    step(1); step(1); step(1);
    drain("trcd");
    chk_flags("trcd");

    // Re-open after only one precharge cycle.
    step(0, 16'h0007); step(0); step(0);
    step(0, 16'h0007, 1, 5);
    step(1);
    step(0, 16'h0007); step(0); step(0);
    step(0, 16'h0007, 0, 0, 1, 1, 1, 64'h0BAD_F00D_CAFE_0007);
    step(0, 16'h0007, 1, 1);
    step(1); step(1); step(1);
    drain("trp");
    chk_flags("trp");

    // Refresh sessions, then a session with a read leaves the count alone.
    for (int r = 1; r <= 3; r++) begin
      step(0, 16'(r)); step(1); step(1); step(1);
    end
    chk_flags("refresh3");
    step(0, 16'h0003); step(0); step(0);
    step(0, 16'h0003, 1, 5);
    step(1); step(1); step(1);
    drain("refresh_rd");
    chk_flags("refresh_rd");

    // Same-cycle write and read.
    step(0, 16'h0002); step(0); step(0);
    step(0, 16'h0002, 0, 0, 1, 1, 9, 64'h5555_5555_5555_5555);
    step(0, 16'h0002, 1, 9, 1, 1, 9, 64'hAAAA_AAAA_AAAA_AAAA);
    step(0, 16'h0002, 1, 9);
    step(1); step(1); step(1);
    drain("conflict");
    chk_flags("conflict");

    // Random sessions, including row aliasing and short precharge gaps.
    for (int s = 0; s < 40; s++) begin
      len = $urandom_range(1, 8);
      step(0, 16'($urandom));
      for (int k = 1; k <= len; k++)
        step(0, 16'h0, ($urandom % 3) == 0, $urandom_range(0, 7),
             ($urandom % 3) == 0, ($urandom % 4) != 0, $urandom_range(0, 7),
             {$urandom, $urandom});
      step(1);
      g = $urandom_range(0, 2);
      for (int k = 0; k < g; k++) step(1);
      if ((s % 8) == 7) begin
        step(1); step(1);
        drain("rand");
        chk_flags("rand");
      end
    end
    step(1); step(1);
    drain("rand_end");
    chk_flags("rand_end");

    // Reset with a read in flight: the response must never appear.
    step(0, 16'h0003); step(0); step(0);
    step(0, 16'h0003, 1, 5);
    #2;
    rst_n = 1'b0;
    array_cs_n = 1'b1; array_caddr_vld_rd = 1'b0;
    model_reset();
    #1;
    chk("midrst.rdata", array_rdata, 64'd0);
    chk("midrst.rdata_vld", 64'(array_rdata_vld), 64'd0);
    chk_flags("midrst");
    @(posedge clk); #1; rst_n = 1'b1;
    repeat (6) step(1);
    chk("postrst.rdata", array_rdata, 64'd0);
    chk_flags("postrst");
    step(0, 16'h0003); step(0); step(0);
    step(0, 16'h0003, 1, 5);
    step(1); step(1); step(1);
    drain("postrst_rd");

    // Counter wrap: preload the count, then one refresh session.
    @(negedge clk);
    force dut.rf_cnt_q = 16'hFFFF;
    @(posedge clk);
    @(negedge clk);
    release dut.rf_cnt_q;
    e_rf = 16'hFFFF;
    step(1);
    chk_flags("rf_preload");
    step(0, 16'h0001); step(1); step(1); step(1);
    chk_flags("rf_wrap");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
